input_skew_feeder: RTL and testbench

- Feeds the systolic array's row inputs. It is the write-side counterpart to the activation block, which drains the array's outputs.
- Accepts one N-element vector per beat over a valid/ready handshake from the input buffer.
- Skews the vector diagonally: lane i is delayed i cycles relative to lane 0, so the array sees correctly staggered wavefronts.
- After the last beat, flushes the skew pipeline and pulses done.

---
 rtl/input_skew_feeder.sv | 133 +++++++++++++
 tb/tb_input_skew_feeder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_skew_feeder.sv
// Diagonal skew feeder for the systolic array row inputs.
// Accepts N-lane vectors over valid/ready, staggers lane i by i cycles, then flushes and pulses done.
module input_skew_feeder #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_last,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_valid,
    output logic           busy,
    output logic           done,
    output logic [15:0]    beat_count
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    localparam int CW = $clog2(N + 1);

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic            accept;
    logic [N*W-1:0]  in_q;
    logic            in_v_q;
    logic [N-1:0]    valid_sr;

    assign accept = in_valid & in_ready & ~clear;

    // FLUSH spans N+1 cycles: one for the input capture register plus N for the deepest lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            beat_count <= '0;
        end else if (clear) begin
            state     <= IDLE;
            flush_cnt <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        beat_count <= 16'd1;
                        flush_cnt  <= '0;
                        busy       <= 1'b1;
                        if (in_last) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
                        if (in_last) begin
                            state     <= FLUSH;
                            in_ready  <= 1'b0;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == CW'(N)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Input capture stage; a cycle without an accept injects a zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q     <= '0;
            in_v_q   <= 1'b0;
            valid_sr <= '0;
        end else if (clear) begin
            in_q     <= '0;
            in_v_q   <= 1'b0;
            valid_sr <= '0;
        end else begin
            in_q     <= accept ? in_data : '0;
            in_v_q   <= accept;
            valid_sr <= {valid_sr[N-2:0], in_v_q};
        end
    end

    assign out_valid = valid_sr;

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [W-1:0] sr [g+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= g; j++) sr[j] <= '0;
            end else if (clear) begin
                for (int j = 0; j <= g; j++) sr[j] <= '0;
            end else begin
                sr[0] <= in_q[g*W +: W];
                for (int j = 1; j <= g; j++) sr[j] <= sr[j-1];
            end
        end

        assign out_data[g*W +: W] = sr[g];
    end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Self-checking bench for input_skew_feeder: edge-indexed history model plus directed literal checks.
module tb_input_skew_feeder;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_data = '0;
    logic           in_last = 1'b0;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic           busy;
    logic           done;
    logic [15:0]    beat_count;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    input_skew_feeder #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    // Model: m_pipe_*[j] holds what was captured j edges ago; lane i shows entry i+1.
    logic [N*W-1:0] m_pipe_d [N+1];
    logic           m_pipe_v [N+1];
    logic           m_stream = 1'b0;
    logic           m_flush = 1'b0;
    logic [15:0]    m_count = '0;
    int             m_t = 0;
    int             m_last_edge = 0;
    logic           m_acc;
    logic           m_ready;
    logic           m_busy;
    logic           m_done;

    assign m_acc   = in_valid && m_ready && !clear;
    assign m_ready = !m_flush;
    assign m_busy  = m_stream || m_flush;
    assign m_done  = m_flush && (m_t == m_last_edge + N + 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= N; j++) begin
                m_pipe_d[j] <= '0;
                m_pipe_v[j] <= 1'b0;
            end
            m_stream    <= 1'b0;
            m_flush     <= 1'b0;
            m_count     <= '0;
            m_t         <= 0;
            m_last_edge <= 0;
        end else begin
            m_t <= m_t + 1;
            for (int j = 1; j <= N; j++) begin
                m_pipe_d[j] <= clear ? '0 : m_pipe_d[j-1];
                m_pipe_v[j] <= clear ? 1'b0 : m_pipe_v[j-1];
            end
            m_pipe_d[0] <= m_acc ? in_data : '0;
            m_pipe_v[0] <= m_acc;
            if (clear) begin
                m_stream <= 1'b0;
                m_flush  <= 1'b0;
            end else if (m_acc) begin
                if (!m_stream) m_count <= 16'd1;
                else if (m_count != 16'hFFFF) m_count <= m_count + 16'd1;
                if (in_last) begin
                    m_stream    <= 1'b0;
                    m_flush     <= 1'b1;
                    m_last_edge <= m_t + 1;
                end else begin
                    m_stream <= 1'b1;
                end
            end else if (m_flush && (m_t + 1 == m_last_edge + N + 2)) begin
                m_flush <= 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                check_output("lane_valid", 64'(out_valid[i]), 64'(m_pipe_v[i+1]));
                check_output("lane_data", 64'(out_data[i*W +: W]), 64'(m_pipe_d[i+1][i*W +: W]));
            end
            check_output("in_ready", 64'(in_ready), 64'(m_ready));
            check_output("busy", 64'(busy), 64'(m_busy));
            check_output("done", 64'(done), 64'(m_done));
            check_output("beat_count", 64'(beat_count), 64'(m_count));
            if (done) done_seen++;
        end
    end

    task automatic apply_stimulus(input logic v, input logic [N*W-1:0] d, input logic l, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        clear    = c;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(in_ready && !busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_timeout", 64'(in_ready && !busy), 64'd1);
    endtask

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    logic [N*W-1:0] va, vb, vc, vtmp;
    int sent, cyc, done_base;
    logic rv;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_reset_ready", 64'(in_ready), 64'd1);
        check_output("post_reset_count", 64'(beat_count), 64'd0);
        check_output("post_reset_valid", 64'(out_valid), 64'd0);

        // Test 1: async reset mid-stream
        apply_stimulus(1'b1, rand_vec(), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_vec(), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_vec(), 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_output("t1_rst_valid", 64'(out_valid), 64'd0);
        check_output("t1_rst_busy", 64'(busy), 64'd0);
        check_output("t1_rst_done", 64'(done), 64'd0);
        check_output("t1_rst_count", 64'(beat_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("t1_ready_after", 64'(in_ready), 64'd1);

        // Test 2: single vector {4,3,2,1} with last
        apply_stimulus(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check_output("t2_lane_data", 64'(out_data[i*W +: W]), 64'(i + 1));
            check_output("t2_lane_valid", 64'(out_valid[i]), 64'd1);
        end
        @(negedge clk);
        check_output("t2_done", 64'(done), 64'd1);
        check_output("t2_count", 64'(beat_count), 64'd1);
        @(negedge clk);
        check_output("t2_ready_back", 64'(in_ready), 64'd1);
        check_output("t2_done_low", 64'(done), 64'd0);

        // Test 3: back-to-back A,B,C
        va = rand_vec(); vb = rand_vec(); vc = rand_vec();
        apply_stimulus(1'b1, va, 1'b0, 1'b0);
        apply_stimulus(1'b1, vb, 1'b0, 1'b0);
        apply_stimulus(1'b1, vc, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("t3_lane3_a", 64'(out_data[3*W +: W]), 64'(va[3*W +: W]));
        @(negedge clk);
        check_output("t3_lane3_b", 64'(out_data[3*W +: W]), 64'(vb[3*W +: W]));
        @(negedge clk);
        check_output("t3_lane3_c", 64'(out_data[3*W +: W]), 64'(vc[3*W +: W]));
        wait_idle(40);
        check_output("t3_count", 64'(beat_count), 64'd3);

        // Test 4: A, bubble, B(last)
        va = rand_vec(); vb = rand_vec();
        apply_stimulus(1'b1, va, 1'b0, 1'b0);
        apply_stimulus(1'b0, rand_vec(), 1'b0, 1'b0);
        apply_stimulus(1'b1, vb, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("t4_lane3_a", 64'(out_data[3*W +: W]), 64'(va[3*W +: W]));
        @(negedge clk);
        check_output("t4_lane3_bubble_v", 64'(out_valid[3]), 64'd0);
        check_output("t4_lane3_bubble_d", 64'(out_data[3*W +: W]), 64'd0);
        @(negedge clk);
        check_output("t4_lane3_b", 64'(out_data[3*W +: W]), 64'(vb[3*W +: W]));
        @(negedge clk);
        check_output("t4_done", 64'(done), 64'd1);
        check_output("t4_count", 64'(beat_count), 64'd2);
        wait_idle(20);

        // Test 5: clear colliding with an accept in STREAM
        done_base = done_seen;
        apply_stimulus(1'b1, rand_vec(), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_vec(), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_vec(), 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("t5_valid_clear", 64'(out_valid), 64'd0);
        check_output("t5_count_held", 64'(beat_count), 64'd2);
        check_output("t5_busy", 64'(busy), 64'd0);
        repeat (N + 3) @(negedge clk);
        check_output("t5_no_done", 64'(done_seen - done_base), 64'd0);
        apply_stimulus(1'b1, rand_vec(), 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("t5_restart_count", 64'(beat_count), 64'd1);
        wait_idle(20);

        // Test 6: 100 random vectors with random gaps
        done_base = done_seen;
        sent = 0;
        cyc = 0;
        while (sent < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            rv = ($urandom_range(0, 2) != 0);
            vtmp = rand_vec();
            in_valid = rv;
            in_data  = vtmp;
            in_last  = (sent == 99);
            clear    = 1'b0;
            if (rv && in_ready) sent++;
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("t6_sent", 64'(sent), 64'd100);
        wait_idle(50);
        check_output("t6_done_pulses", 64'(done_seen - done_base), 64'd1);
        check_output("t6_count", 64'(beat_count), 64'd100);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
